ace_snapshot_encoder: RTL and testbench

- Reads Jupiter Ace RAM from 0x2000 up to a programmable end address.
- Produces the compressed .ACE byte stream that the ACE loader accepts, for upload to HPS.
- Encoding is RLE: escape byte 0xED, then a count byte, then a data byte. The pair ED 00 terminates the stream.
- Sits between the ace RAM read port (shared with the CPU during save) and the hps_io upload path.

---
 rtl/ace_pkg.sv | 21 ++
 rtl/ace_rle_emitter.sv | 85 ++++++++
 rtl/ace_snapshot_encoder.sv | 141 ++++++++++++++
 tb/tb_ace_snapshot_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ace_pkg.sv
// Shared Jupiter Ace constants and encoder state/mode codes.
// The snapshot loader uses the same escape byte and load base.
package ace_pkg;

  localparam logic [7:0]  ACE_ESC  = 8'hED;
  localparam logic [15:0] ACE_BASE = 16'h2000;

  typedef logic [2:0] ace_enc_state_t;
  localparam ace_enc_state_t ACE_ST_IDLE    = 3'd0;
  localparam ace_enc_state_t ACE_ST_FETCH   = 3'd1;
  localparam ace_enc_state_t ACE_ST_CAPTURE = 3'd2;
  localparam ace_enc_state_t ACE_ST_ACCUM   = 3'd3;
  localparam ace_enc_state_t ACE_ST_FLUSH   = 3'd4;
  localparam ace_enc_state_t ACE_ST_TERM    = 3'd5;

  typedef logic [1:0] ace_emit_mode_t;
  localparam ace_emit_mode_t ACE_EMIT_LIT  = 2'd0;
  localparam ace_emit_mode_t ACE_EMIT_ESC  = 2'd1;
  localparam ace_emit_mode_t ACE_EMIT_TERM = 2'd2;

endpackage

// File: rtl/ace_rle_emitter.sv
// Serialises one run (or the ED 00 terminator) into output bytes.
// The ack pulses when the last byte of the run has been accepted by the sink.
module ace_rle_emitter
  import ace_pkg::*;
#(
  parameter int MIN_RUN = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       run_req,
  input  logic [7:0] run_val,
  input  logic [7:0] run_cnt,
  output logic       run_ack,
  input  logic       term_req,
  output logic       term_ack,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  localparam logic [7:0] MIN_RUN_B = 8'(MIN_RUN);

  ace_emit_mode_t mode;
  logic [7:0]     val_q;
  logic [7:0]     cnt_q;
  logic [7:0]     remain;
  logic           final_fire;

  assign final_fire = out_valid && out_ready && (remain == 8'd0);
  assign run_ack    = final_fire && (mode != ACE_EMIT_TERM);
  assign term_ack   = final_fire && (mode == ACE_EMIT_TERM);

  // remain counts bytes still to follow the one currently presented
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      mode      <= ACE_EMIT_LIT;
      val_q     <= 8'h00;
      cnt_q     <= 8'h00;
      remain    <= 8'd0;
    end else if (out_valid) begin
      if (out_ready) begin
        if (remain == 8'd0) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          remain <= remain - 8'd1;
          case (mode)
            ACE_EMIT_TERM: begin
              out_data <= 8'h00;
              out_last <= 1'b1;
            end
            ACE_EMIT_ESC:  out_data <= (remain == 8'd2) ? cnt_q : val_q;
            default:       out_data <= val_q;
          endcase
        end
      end
    end else if (term_req) begin
      mode      <= ACE_EMIT_TERM;
      out_data  <= ACE_ESC;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      remain    <= 8'd1;
    end else if (run_req) begin
      val_q     <= run_val;
      cnt_q     <= run_cnt;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      // a raw ED must always be escaped so the loader never mistakes it
      if (run_val == ACE_ESC || run_cnt >= MIN_RUN_B) begin
        mode     <= ACE_EMIT_ESC;
        out_data <= ACE_ESC;
        remain   <= 8'd2;
      end else begin
        mode     <= ACE_EMIT_LIT;
        out_data <= run_val;
        remain   <= run_cnt - 8'd1;
      end
    end
  end

endmodule

// File: rtl/ace_snapshot_encoder.sv
// Reads Ace RAM from START_ADDR to end_addr and produces the RLE .ACE stream.
// Fetching pauses whenever the emitter is busy, so at most one byte is in flight.
module ace_snapshot_encoder
  import ace_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(ACE_BASE),
  parameter int                MIN_RUN    = 4,
  parameter int                MAX_RUN    = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [7:0] MAX_RUN_B = 8'(MAX_RUN);

  ace_enc_state_t    state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] end_q;
  logic [7:0]        cur;
  logic [7:0]        run_val;
  logic [7:0]        run_cnt;
  logic              load_cur;
  logic              final_q;
  logic              is_last;
  logic              run_ack;
  logic              term_ack;

  assign mem_rd   = (state == ACE_ST_FETCH);
  assign mem_addr = addr;
  assign is_last  = (addr == end_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ACE_ST_IDLE;
      addr     <= START_ADDR;
      end_q    <= START_ADDR;
      cur      <= 8'h00;
      run_val  <= 8'h00;
      run_cnt  <= 8'd0;
      load_cur <= 1'b0;
      final_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ACE_ST_IDLE: begin
          if (start) begin
            end_q    <= end_addr;
            addr     <= START_ADDR;
            run_cnt  <= 8'd0;
            load_cur <= 1'b0;
            busy     <= 1'b1;
            state    <= (end_addr < START_ADDR) ? ACE_ST_TERM : ACE_ST_FETCH;
          end
        end
        ACE_ST_FETCH:   state <= ACE_ST_CAPTURE;
        ACE_ST_CAPTURE: begin
          cur   <= mem_data;
          state <= ACE_ST_ACCUM;
        end
        ACE_ST_ACCUM: begin
          final_q <= is_last;
          if (run_cnt != 8'd0 && !(cur == run_val && run_cnt < MAX_RUN_B)) begin
            load_cur <= 1'b1;
            state    <= ACE_ST_FLUSH;
          end else begin
            if (run_cnt != 8'd0) begin
              run_cnt <= run_cnt + 8'd1;
            end else begin
              run_val <= cur;
              run_cnt <= 8'd1;
            end
            if (is_last) begin
              state <= ACE_ST_FLUSH;
            end else begin
              addr  <= addr + 1'b1;
              state <= ACE_ST_FETCH;
            end
          end
        end
        // after flushing a broken run the pending byte starts the next one;
        // on the final address that new run is flushed too before the terminator
        ACE_ST_FLUSH: begin
          if (run_ack) begin
            if (load_cur) begin
              run_val  <= cur;
              run_cnt  <= 8'd1;
              load_cur <= 1'b0;
              if (!final_q) begin
                addr  <= addr + 1'b1;
                state <= ACE_ST_FETCH;
              end
            end else begin
              run_cnt <= 8'd0;
              state   <= ACE_ST_TERM;
            end
          end
        end
        ACE_ST_TERM: begin
          if (term_ack) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ACE_ST_IDLE;
          end
        end
        default: state <= ACE_ST_IDLE;
      endcase
    end
  end

  ace_rle_emitter #(
    .MIN_RUN(MIN_RUN)
  ) u_emitter (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .run_req  (state == ACE_ST_FLUSH),
    .run_val  (run_val),
    .run_cnt  (run_cnt),
    .run_ack  (run_ack),
    .term_req (state == ACE_ST_TERM),
    .term_ack (term_ack),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

endmodule

// File: tb/tb_ace_snapshot_encoder.sv
// Self-checking bench: RAM model plus a run-length reference encoder built from
// plain grouping of equal bytes, compared byte by byte with the DUT stream.
module tb_ace_snapshot_encoder;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] end_addr;
  logic        busy;
  logic        done;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  logic [7:0] mem [0:65535];

  int vectorCount = 0;
  int missCount   = 0;
  byte unsigned expQ[$];
  byte unsigned gotQ[$];
  int lastCount, lastIdx, doneCount, rdCount, stallRd, unstable;

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (mem_rd) mem_data <= mem[mem_addr];

  ace_snapshot_encoder dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (start),
    .end_addr (end_addr),
    .busy     (busy),
    .done     (done),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Group equal bytes, cap each group at 255, escape ED or groups of 4+
  function automatic void buildExpected(input int endA);
    int i, n;
    byte unsigned v;
    expQ.delete();
    i = 'h2000;
    while (i <= endA) begin
      v = mem[i];
      n = 0;
      while (i <= endA && mem[i] == v && n < 255) begin
        n++;
        i++;
      end
      if (v == 8'hED || n >= 4) begin
        expQ.push_back(8'hED);
        expQ.push_back(8'(n));
        expQ.push_back(v);
      end else begin
        for (int k = 0; k < n; k++) expQ.push_back(v);
      end
    end
    expQ.push_back(8'hED);
    expQ.push_back(8'h00);
  endfunction

  task automatic applyStimulus(input int endA, input bit randReady, input bit extraStart);
    bit held, finished;
    logic [7:0] heldData;
    int expRd, extra;
    gotQ.delete();
    lastCount = 0; lastIdx = -1; doneCount = 0; rdCount = 0; stallRd = 0; unstable = 0;
    held = 0; heldData = 0; finished = 0; extra = 0;
    buildExpected(endA);
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      @(negedge clk_sys);
      start = (cyc == 0) || (extraStart && cyc == 6);
      if (cyc == 0) end_addr = 16'(endA);
      else if (extraStart && cyc == 6) end_addr = 16'(endA + 7);
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held && (!out_valid || out_data !== heldData)) unstable++;
      if (mem_rd && out_valid) stallRd++;
      if (mem_rd) rdCount++;
      if (done) begin
        doneCount++;
        checkOutput("busy_at_done", int'(busy), 0);
        finished = 1;
      end
      if (out_valid && out_ready) begin
        gotQ.push_back(out_data);
        if (out_last) begin
          lastCount++;
          lastIdx = gotQ.size() - 1;
        end
      end
      held = out_valid && !out_ready;
      heldData = out_data;
    end
    start = 1'b0;
    if (!finished) checkOutput("timeout", 0, 1);
    repeat (3) begin
      @(negedge clk_sys);
      if (done) doneCount++;
      if (out_valid) extra++;
    end
    expRd = (endA >= 'h2000) ? endA - 'h2000 + 1 : 0;
    checkOutput("stream_len", gotQ.size(), expQ.size());
    for (int k = 0; k < expQ.size(); k++)
      checkOutput($sformatf("byte%0d", k), (k < gotQ.size()) ? int'(gotQ[k]) : -1, int'(expQ[k]));
    checkOutput("last_count", lastCount, 1);
    checkOutput("last_pos", lastIdx, expQ.size() - 1);
    checkOutput("done_count", doneCount, 1);
    checkOutput("mem_rd_count", rdCount, expRd);
    checkOutput("rd_during_stall", stallRd, 0);
    checkOutput("data_unstable", unstable, 0);
    checkOutput("idle_after_done", extra, 0);
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_busy"}, int'(busy), 0);
    checkOutput({pfx, "_done"}, int'(done), 0);
    checkOutput({pfx, "_mem_rd"}, int'(mem_rd), 0);
    checkOutput({pfx, "_mem_addr"}, int'(mem_addr), 'h2000);
    checkOutput({pfx, "_out_valid"}, int'(out_valid), 0);
    checkOutput({pfx, "_out_last"}, int'(out_last), 0);
    checkOutput({pfx, "_out_data"}, int'(out_data), 0);
  endtask

  task automatic fillBytes(input int base, input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) mem[base + i] = v;
  endtask

  initial begin
    int len, pos, seg, quiet;
    logic [7:0] v;
    reset = 1'b1; start = 1'b0; end_addr = '0; out_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk_sys);
    checkResetValues("rst");
    reset = 1'b0;

    for (int i = 0; i < 4; i++) mem['h2000 + i] = 8'(i + 1);
    applyStimulus('h2003, 0, 0);
    fillBytes('h2000, 10, 8'h00);
    applyStimulus('h2009, 0, 0);
    mem['h2000] = 8'hED;
    applyStimulus('h2000, 0, 0);
    fillBytes('h2000, 300, 8'h55);
    applyStimulus('h212B, 0, 1);
    fillBytes('h2000, 3, 8'hAA);
    applyStimulus('h2002, 0, 0);
    for (int i = 0; i < 4; i++) mem['h2000 + i] = 8'(i + 1);
    applyStimulus('h2003, 1, 0);
    applyStimulus('h1FFF, 1, 0);

    // abort after two accepted bytes, then require a clean restart
    gotQ.delete();
    @(negedge clk_sys);
    start = 1'b1; end_addr = 16'h2003; out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && gotQ.size() < 2; cyc++) begin
      @(negedge clk_sys);
      start = 1'b0;
      if (out_valid && out_ready) gotQ.push_back(out_data);
    end
    checkOutput("rst_bytes_before", gotQ.size(), 2);
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    checkResetValues("midrst");
    reset = 1'b0;
    quiet = 0;
    repeat (5) begin
      @(negedge clk_sys);
      if (out_valid || busy) quiet++;
    end
    checkOutput("rst_quiet", quiet, 0);
    applyStimulus('h2003, 1, 0);

    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 400);
      pos = 0;
      while (pos < len) begin
        case ($urandom_range(0, 3))
          0: v = 8'h00;
          1: v = 8'hED;
          2: v = 8'h55;
          default: v = 8'($urandom);
        endcase
        seg = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 6);
        for (int k = 0; k < seg && pos < len; k++) begin
          mem['h2000 + pos] = v;
          pos++;
        end
      end
      applyStimulus('h2000 + len - 1, 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
